// File: rtl/switch_demux_pkg.sv
// Shared definitions for the switch demultiplexer: select encodings and
// the default counter width.
package switch_demux_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_CH1  = 2'b00;
  localparam sel_t SEL_CH2  = 2'b01;
  localparam sel_t SEL_CH3  = 2'b10;
  localparam sel_t SEL_DROP = 2'b11;

endpackage

// File: rtl/switch_demux_chan.sv
// One output channel: a single-entry buffer with valid/ready handshake and a
// counter of completed output transfers.
module demux_chan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             din,
  input  logic             rdy,
  output logic             dout,
  output logic             valid,
  output logic             space,
  output logic [CNT_W-1:0] cnt
);

  logic xfer;

  assign xfer  = valid & rdy;
  // The buffer can take a new bit when empty or when it is draining this cycle.
  assign space = ~valid | rdy;

  // A load wins over the transfer's clear, so a simultaneous drain and refill keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= 1'b0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      if (load) begin
        dout  <= din;
        valid <= 1'b1;
      end else if (xfer) begin
        valid <= 1'b0;
      end
      if (xfer) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_demux.sv
// Routes a gated data bit to one of three buffered channels or drops it,
// counting transfers per channel and dropped offers.
module switch_demux
  import switch_demux_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             s1,
  input  logic             s2,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             B1,
  output logic             B2,
  output logic             B3,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] drop_cnt
);

  sel_t sel;
  logic gated;
  logic accept;
  logic space1, space2, space3;
  logic load1, load2, load3;

  assign sel    = {s1, s2};
  assign gated  = din & s;
  assign accept = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b1;
    case (sel)
      SEL_CH1:  in_ready = space1;
      SEL_CH2:  in_ready = space2;
      SEL_CH3:  in_ready = space3;
      default:  in_ready = 1'b1;
    endcase
  end

  assign load1 = accept & (sel == SEL_CH1);
  assign load2 = accept & (sel == SEL_CH2);
  assign load3 = accept & (sel == SEL_CH3);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && sel == SEL_DROP) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  demux_chan #(.CNT_W(CNT_W)) u_ch1 (
    .clk(clk), .rst(rst), .load(load1), .din(gated), .rdy(r1),
    .dout(B1), .valid(v1), .space(space1), .cnt(cnt1)
  );

  demux_chan #(.CNT_W(CNT_W)) u_ch2 (
    .clk(clk), .rst(rst), .load(load2), .din(gated), .rdy(r2),
    .dout(B2), .valid(v2), .space(space2), .cnt(cnt2)
  );

  demux_chan #(.CNT_W(CNT_W)) u_ch3 (
    .clk(clk), .rst(rst), .load(load3), .din(gated), .rdy(r3),
    .dout(B3), .valid(v3), .space(space3), .cnt(cnt3)
  );

endmodule

// File: tb/tb_switch_demux.sv
// Self-checking bench for switch_demux: a per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_switch_demux;

  logic       clk = 1'b0;
  logic       rst, din, s1, s2, s, in_valid, in_ready;
  logic       B1, B2, B3, v1, v2, v3, r1, r2, r3;
  logic [7:0] cnt1, cnt2, cnt3, drop_cnt;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Reference state: index 0..2 is channel 1..3.
  bit       mv [3];
  bit       mb [3];
  bit [7:0] mc [3];
  bit [7:0] mdrop;

  always #5 clk = ~clk;

  switch_demux #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .s1(s1), .s2(s2), .s(s),
    .in_valid(in_valid), .in_ready(in_ready),
    .B1(B1), .B2(B2), .B3(B3), .v1(v1), .v2(v2), .v3(v3),
    .r1(r1), .r2(r2), .r3(r3),
    .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .drop_cnt(drop_cnt)
  );

  function automatic bit model_ready();
    int k;
    bit [2:0] rv;
    rv = {r3, r2, r1};
    k  = int'({s1, s2});
    if (k == 3) return 1'b1;
    return !mv[k] || rv[k];
  endfunction

  // Model advances on each rising edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    bit [2:0] rv;
    bit       rdy_now;
    int       k;
    rv      = {r3, r2, r1};
    k       = int'({s1, s2});
    rdy_now = model_ready();
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] = 1'b0; mb[i] = 1'b0; mc[i] = 8'd0;
      end
      mdrop = 8'd0;
    end else begin
      if (in_valid && rdy_now && k == 3) mdrop = mdrop + 8'd1;
      for (int i = 0; i < 3; i++) begin
        bit sent, took;
        sent = mv[i] && rv[i];
        took = in_valid && rdy_now && k == i;
        if (sent) mc[i] = mc[i] + 8'd1;
        if (took) begin
          mb[i] = din & s;
          mv[i] = 1'b1;
        end else if (sent) begin
          mv[i] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("m_in_ready", {7'd0, in_ready}, {7'd0, model_ready()});
      checkOutput("m_v", {5'd0, v3, v2, v1}, {5'd0, mv[2], mv[1], mv[0]});
      checkOutput("m_B", {5'd0, B3, B2, B1}, {5'd0, mb[2], mb[1], mb[0]});
      checkOutput("m_cnt1", cnt1, mc[0]);
      checkOutput("m_cnt2", cnt2, mc[1]);
      checkOutput("m_cnt3", cnt3, mc[2]);
      checkOutput("m_drop", drop_cnt, mdrop);
    end
  end

  // Inputs change shortly after the rising edge; results are read at the falling edge.
  task automatic applyStimulus(input bit rs, input bit iv, input bit [1:0] sel,
                               input bit d, input bit en, input bit [2:0] rv);
    @(posedge clk);
    #2;
    rst = rs; in_valid = iv; {s1, s2} = sel; din = d; s = en; {r3, r2, r1} = rv;
    @(negedge clk);
  endtask

  task automatic idle(input bit [2:0] rv);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, rv);
  endtask

  initial begin
    rst = 1'b1; din = 0; s1 = 0; s2 = 0; s = 0; in_valid = 0; r1 = 0; r2 = 0; r3 = 0;
    @(posedge clk);
    #1 started = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
    idle(3'b000);
    checkOutput("reset_v", {5'd0, v3, v2, v1}, 8'd0);
    checkOutput("reset_cnt2", cnt2, 8'd0);
    checkOutput("reset_drop", drop_cnt, 8'd0);

    // Basic accept then drain on channel 2.
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 3'b010);
    checkOutput("ch2_ready", {7'd0, in_ready}, 8'd1);
    idle(3'b010);
    checkOutput("ch2_v_load", {7'd0, v2}, 8'd1);
    checkOutput("ch2_B_load", {7'd0, B2}, 8'd1);
    idle(3'b000);
    checkOutput("ch2_cnt", cnt2, 8'd1);
    checkOutput("ch2_v_drain", {7'd0, v2}, 8'd0);

    // Enable gating into channel 1, which then stays blocked.
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 3'b000);
    idle(3'b000);
    checkOutput("gate_B1", {7'd0, B1}, 8'd0);
    checkOutput("gate_v1", {7'd0, v1}, 8'd1);

    // Channel 2 accepts while channel 1 stalls.
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 3'b010);
    checkOutput("indep_ready", {7'd0, in_ready}, 8'd1);
    idle(3'b000);
    checkOutput("indep_v2", {7'd0, v2}, 8'd1);
    checkOutput("indep_B1", {7'd0, B1}, 8'd0);
    checkOutput("indep_v1", {7'd0, v1}, 8'd1);

    // Channel 3 backpressure, then same-cycle drain and refill.
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 3'b000);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 3'b000);
    checkOutput("bp_ready", {7'd0, in_ready}, 8'd0);
    idle(3'b000);
    checkOutput("bp_B3_held", {7'd0, B3}, 8'd1);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 3'b100);
    checkOutput("refill_ready", {7'd0, in_ready}, 8'd1);
    idle(3'b000);
    checkOutput("refill_v3", {7'd0, v3}, 8'd1);
    checkOutput("refill_B3", {7'd0, B3}, 8'd0);
    checkOutput("refill_cnt3", cnt3, 8'd1);

    // Reset with every buffer full and an accept/transfer pending.
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 3'b111);
    checkOutput("rst_ready", {7'd0, in_ready}, 8'd1);
    idle(3'b000);
    checkOutput("rst_v", {5'd0, v3, v2, v1}, 8'd0);
    checkOutput("rst_B", {5'd0, B3, B2, B1}, 8'd0);
    checkOutput("rst_cnt1", cnt1, 8'd0);
    checkOutput("rst_cnt3", cnt3, 8'd0);

    // 256 dropped offers wrap the drop counter back to zero.
    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 3'b000);
    idle(3'b000);
    checkOutput("drop_wrap", drop_cnt, 8'd0);
    checkOutput("drop_v", {5'd0, v3, v2, v1}, 8'd0);

    // Streaming into channel 1 wraps its transfer counter.
    for (int i = 0; i < 257; i++) applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 3'b001);
    idle(3'b001);
    checkOutput("stream_cnt1", cnt1, 8'd0);
    checkOutput("stream_v1", {7'd0, v1}, 8'd1);
    idle(3'b000);
    checkOutput("stream_cnt1_last", cnt1, 8'd1);
    checkOutput("stream_v1_last", {7'd0, v1}, 8'd0);

    // Mixed traffic with occasional reset, checked by the model alone.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 40) == 0, 1'(($urandom_range(0, 3)) != 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    @(posedge clk);
    #1 started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_demux.md
SWITCH_DEMUX -- requirements
Module: switch_demux

Interface
REQ-001 Parameter CNT_W, default 8: width of the per-channel and drop counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 din  input  1  data bit to be routed.
REQ-005 s1, s2  input  1 each  channel select {s1,s2}: 00->ch1, 01->ch2, 10->ch3, 11->drop.
REQ-006 s  input  1  data enable; the delivered bit is din AND s.
REQ-007 in_valid  input  1  upstream offers din/s1/s2/s this cycle.
REQ-008 in_ready  output  1  block accepts the offer this cycle.
REQ-009 B1, B2, B3  output  1 each  buffered data of channels 1..3.
REQ-010 v1, v2, v3  output  1 each  channel buffer holds valid data.
REQ-011 r1, r2, r3  input  1 each  downstream ready per channel.
REQ-012 cnt1, cnt2, cnt3  output  CNT_W each  completed output transfers per channel.
REQ-013 drop_cnt  output  CNT_W  accepted offers with select 11.

Function
REQ-014 Each channel k SHALL be a one-entry buffer with two states: EMPTY (vk=0) and FULL (vk=1).
REQ-015 Input accept SHALL be in_valid AND in_ready, where in_ready = 1 for select 11, else (vk=0 OR rk=1) for the selected channel k.
REQ-016 in_ready SHALL depend only on the current select, channel state and rk: combinational, not registered.
REQ-017 On accept to channel k: Bk <= din AND s, and vk <= 1, effective next edge (latency 1 cycle).
REQ-018 Output transfer on channel k SHALL occur when vk=1 AND rk=1; on it, cntk increments by 1.
REQ-019 Transfer and accept on the same channel in the same cycle: the buffer reloads with the new bit, vk stays 1, and cntk increments.
REQ-020 Transfer without accept: vk <= 0; Bk holds its last value.
REQ-021 vk=1 AND rk=0: Bk and vk SHALL hold stable until transfer.
REQ-022 Accept with select 11: no channel changes and drop_cnt increments by 1.
REQ-023 Channels SHALL be independent: transfers on non-selected channels proceed in the same cycle as an accept to another channel.
REQ-024 Counters SHALL wrap modulo 2^CNT_W (255 -> 0 for CNT_W=8) without affecting data flow.
REQ-025 in_valid=0: no state change other than output transfers.

Reset
REQ-026 rst=1 at a rising edge SHALL force B1..B3=0, v1..v3=0, cnt1..cnt3=0, drop_cnt=0, overriding any simultaneous accept or transfer.
REQ-027 Reset mid-operation SHALL discard buffered data; no transfer or count is credited in the reset cycle.
REQ-028 in_ready SHALL follow REQ-015 during reset; an accept in a reset cycle is lost.

Structure
REQ-029 A shared package SHALL hold the select encodings (SEL_CH1=00, SEL_CH2=01, SEL_CH3=10, SEL_DROP=11) and the default CNT_W.
REQ-030 The per-channel buffer plus counter SHALL be one sub-module, demux_chan, instantiated three times; select decode, in_ready and drop counter live in the top.

Verification
REQ-031 After reset, offer din=1, s=1, {s1,s2}=01, r2=1 -> next cycle v2=1, B2=1; following cycle cnt2=1 and v2=0.
REQ-032 Offer din=1, s=0, sel 00 -> B1=0, v1=1 (enable gating).
REQ-033 v3=1, r3=0, offer sel 10 -> in_ready=0 and B3 unchanged; raise r3 -> same-cycle accept, v3 stays 1, cnt3 +1.
REQ-034 256 consecutive sel-11 offers -> drop_cnt returns to 0; v1..v3 remain 0 throughout.
REQ-035 v1=1 with r1=0; offer sel 01 with r2=1 -> accepted to ch2 while ch1 holds B1 unchanged.
REQ-036 Assert rst with all three buffers full and cnt values nonzero -> all outputs 0 next cycle, counts not incremented.
